// File: rtl/io_bus_arbiter.sv
// ============================================================================
// io_bus_arbiter : round-robin two-master arbiter for the IO bus device port
// Revision 1.0
// ============================================================================
`default_nettype none

module io_bus_arbiter #(
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // master 0
  input  logic [31:0] i_m0_dev_id,
  input  logic        if_m0_din_valid,
  input  logic [31:0] if_m0_din_bits,
  output logic        if_m0_din_ready,
  input  logic        if_m0_dout_ready,
  output logic        if_m0_dout_valid,
  output logic [31:0] if_m0_dout_bits,
  // master 1
  input  logic [31:0] i_m1_dev_id,
  input  logic        if_m1_din_valid,
  input  logic [31:0] if_m1_din_bits,
  output logic        if_m1_din_ready,
  input  logic        if_m1_dout_ready,
  output logic        if_m1_dout_valid,
  output logic [31:0] if_m1_dout_bits,
  // IO bus
  output logic [31:0] o_bus_dev_id,
  output logic        if_bus_din_valid,
  output logic [31:0] if_bus_din_bits,
  input  logic        if_bus_din_ready,
  input  logic        if_bus_dout_valid,
  input  logic [31:0] if_bus_dout_bits,
  output logic        if_bus_dout_ready,
  // status
  output logic [1:0]  o_grant,
  output logic        o_timeout,
  output logic        o_timeout_id
);

  localparam int unsigned CNT_W   = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int unsigned TO_LAST = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_e;

  state_e           state_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  logic             timeout_id_q;

  logic w_req0;
  logic w_req1;
  logic w_g0;
  logic w_g1;
  logic w_gid;
  logic w_req_gnt;
  logic w_hs;

  assign w_req0    = if_m0_din_valid | if_m0_dout_ready;
  assign w_req1    = if_m1_din_valid | if_m1_dout_ready;
  assign w_g0      = (state_q == ST_GRANT0);
  assign w_g1      = (state_q == ST_GRANT1);
  assign w_gid     = w_g1;
  assign w_req_gnt = w_g1 ? w_req1 : w_req0;

  // Bus side: selected master's request, all zero while idle
  always_comb begin
    o_bus_dev_id      = 32'd0;
    if_bus_din_valid  = 1'b0;
    if_bus_din_bits   = 32'd0;
    if_bus_dout_ready = 1'b0;
    if (w_g0) begin
      o_bus_dev_id      = i_m0_dev_id;
      if_bus_din_valid  = if_m0_din_valid;
      if_bus_din_bits   = if_m0_din_bits;
      if_bus_dout_ready = if_m0_dout_ready;
    end else if (w_g1) begin
      o_bus_dev_id      = i_m1_dev_id;
      if_bus_din_valid  = if_m1_din_valid;
      if_bus_din_bits   = if_m1_din_bits;
      if_bus_dout_ready = if_m1_dout_ready;
    end
  end

  assign if_m0_din_ready  = w_g0 & if_bus_din_ready;
  assign if_m0_dout_valid = w_g0 & if_bus_dout_valid;
  assign if_m0_dout_bits  = w_g0 ? if_bus_dout_bits : 32'd0;
  assign if_m1_din_ready  = w_g1 & if_bus_din_ready;
  assign if_m1_dout_valid = w_g1 & if_bus_dout_valid;
  assign if_m1_dout_bits  = w_g1 ? if_bus_dout_bits : 32'd0;

  assign w_hs = (if_bus_din_valid & if_bus_din_ready) |
                (if_bus_dout_valid & if_bus_dout_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          // On a tie the master that did not finish last wins
          if (w_req0 && (!w_req1 || last_grant_q)) begin
            state_q <= ST_GRANT0;
          end else if (w_req1) begin
            state_q <= ST_GRANT1;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (w_hs) begin
            state_q      <= ST_IDLE;
            last_grant_q <= w_gid;
            cnt_q        <= '0;
          end else if (!w_req_gnt) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if ((TimeoutCycles > 0) && (cnt_q == CNT_LAST)) begin
            state_q      <= ST_IDLE;
            last_grant_q <= w_gid;
            cnt_q        <= '0;
            timeout_q    <= 1'b1;
            timeout_id_q <= w_gid;
          end else if (TimeoutCycles > 0) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_grant      = {w_g1, w_g0};
  assign o_timeout    = timeout_q;
  assign o_timeout_id = timeout_id_q;

endmodule

`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
// ============================================================================
// tb_io_bus_arbiter : directed self-checking bench for io_bus_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_dev_id, m0_din_bits, m0_dout_bits;
  logic        m0_din_valid, m0_din_ready, m0_dout_ready, m0_dout_valid;
  logic [31:0] m1_dev_id, m1_din_bits, m1_dout_bits;
  logic        m1_din_valid, m1_din_ready, m1_dout_ready, m1_dout_valid;
  logic [31:0] bus_dev_id, bus_din_bits, bus_dout_bits;
  logic        bus_din_valid, bus_din_ready, bus_dout_valid, bus_dout_ready;
  logic [1:0]  grant;
  logic        timeout, timeout_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.TimeoutCycles(8)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_m0_dev_id      (m0_dev_id),
    .if_m0_din_valid  (m0_din_valid),
    .if_m0_din_bits   (m0_din_bits),
    .if_m0_din_ready  (m0_din_ready),
    .if_m0_dout_ready (m0_dout_ready),
    .if_m0_dout_valid (m0_dout_valid),
    .if_m0_dout_bits  (m0_dout_bits),
    .i_m1_dev_id      (m1_dev_id),
    .if_m1_din_valid  (m1_din_valid),
    .if_m1_din_bits   (m1_din_bits),
    .if_m1_din_ready  (m1_din_ready),
    .if_m1_dout_ready (m1_dout_ready),
    .if_m1_dout_valid (m1_dout_valid),
    .if_m1_dout_bits  (m1_dout_bits),
    .o_bus_dev_id     (bus_dev_id),
    .if_bus_din_valid (bus_din_valid),
    .if_bus_din_bits  (bus_din_bits),
    .if_bus_din_ready (bus_din_ready),
    .if_bus_dout_valid(bus_dout_valid),
    .if_bus_dout_bits (bus_dout_bits),
    .if_bus_dout_ready(bus_dout_ready),
    .o_grant          (grant),
    .o_timeout        (timeout),
    .o_timeout_id     (timeout_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_g [8];

  initial begin
    exp_g = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    rst = 1'b1;
    m0_dev_id = '0; m0_din_valid = 1'b0; m0_din_bits = '0; m0_dout_ready = 1'b0;
    m1_dev_id = '0; m1_din_valid = 1'b0; m1_din_bits = '0; m1_dout_ready = 1'b0;
    bus_din_ready = 1'b0; bus_dout_valid = 1'b0; bus_dout_bits = '0;
    tick(); tick();
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_timeout_id", 32'(timeout_id), 32'd0);
    chk("rst_bus_valid", 32'(bus_din_valid), 32'd0);
    chk("rst_bus_dev", bus_dev_id, 32'd0);
    rst = 1'b0;

    // M0 write, bus ready immediately
    tick();
    m0_dev_id = 32'h4; m0_din_bits = 32'hA5; m0_din_valid = 1'b1; bus_din_ready = 1'b1;
    #1;
    chk("w0_c1_bus_valid", 32'(bus_din_valid), 32'd0);
    chk("w0_c1_grant", 32'(grant), 32'd0);
    tick(); #1;
    chk("w0_c2_grant", 32'(grant), 32'b01);
    chk("w0_c2_bus_valid", 32'(bus_din_valid), 32'd1);
    chk("w0_c2_bus_bits", bus_din_bits, 32'hA5);
    chk("w0_c2_bus_dev", bus_dev_id, 32'h4);
    chk("w0_c2_m0_ready", 32'(m0_din_ready), 32'd1);
    chk("w0_c2_m1_ready", 32'(m1_din_ready), 32'd0);
    tick();
    m0_din_valid = 1'b0;
    #1;
    chk("w0_c3_grant", 32'(grant), 32'd0);
    chk("w0_c3_bus_valid", 32'(bus_din_valid), 32'd0);

    // Both masters write continuously; M0 finished last, so M1 goes first
    m0_din_bits = 32'h11; m1_din_bits = 32'h22; m1_dev_id = 32'h8;
    m0_din_valid = 1'b1; m1_din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      chk("rr_grant", 32'(grant), 32'(exp_g[i]));
      chk("rr_m0_ready", 32'(m0_din_ready), 32'(exp_g[i] == 2'b01));
      chk("rr_m1_ready", 32'(m1_din_ready), 32'(exp_g[i] == 2'b10));
    end
    m0_din_valid = 1'b0; m1_din_valid = 1'b0; bus_din_ready = 1'b0;

    // M1 read
    m1_dev_id = 32'h1000; m1_dout_ready = 1'b1;
    bus_dout_valid = 1'b1; bus_dout_bits = 32'h12345678;
    #1;
    chk("rd_idle_m1_valid", 32'(m1_dout_valid), 32'd0);
    chk("rd_idle_bus_ready", 32'(bus_dout_ready), 32'd0);
    tick(); #1;
    chk("rd_grant", 32'(grant), 32'b10);
    chk("rd_bus_dev", bus_dev_id, 32'h1000);
    chk("rd_bus_ready", 32'(bus_dout_ready), 32'd1);
    chk("rd_m1_valid", 32'(m1_dout_valid), 32'd1);
    chk("rd_m1_bits", m1_dout_bits, 32'h12345678);
    chk("rd_m0_valid", 32'(m0_dout_valid), 32'd0);
    chk("rd_m0_bits", m0_dout_bits, 32'd0);
    tick();
    m1_dout_ready = 1'b0; bus_dout_valid = 1'b0; bus_dout_bits = '0;
    #1;
    chk("rd_done_grant", 32'(grant), 32'd0);

    // Watchdog: M1 finished last, so M0 wins the tie, then stalls
    m0_din_valid = 1'b1; m1_din_valid = 1'b1; bus_din_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      chk("wd_grant0", 32'(grant), 32'b01);
      chk("wd_no_pulse", 32'(timeout), 32'd0);
    end
    tick(); #1;
    chk("wd_idle", 32'(grant), 32'd0);
    chk("wd_pulse", 32'(timeout), 32'd1);
    chk("wd_id", 32'(timeout_id), 32'd0);
    tick(); #1;
    chk("wd_next_m1", 32'(grant), 32'b10);
    chk("wd_pulse_end", 32'(timeout), 32'd0);
    bus_din_ready = 1'b1;
    #1;
    chk("wd_m1_ready", 32'(m1_din_ready), 32'd1);
    chk("wd_m0_ready", 32'(m0_din_ready), 32'd0);
    tick();
    m0_din_valid = 1'b0; m1_din_valid = 1'b0; bus_din_ready = 1'b0;

    // Abandon: last_grant stays at M1, so M0 wins the following tie
    m0_din_valid = 1'b1;
    tick(); #1;
    chk("ab_grant0", 32'(grant), 32'b01);
    m0_din_valid = 1'b0;
    #1;
    chk("ab_bus_valid", 32'(bus_din_valid), 32'd0);
    tick(); #1;
    chk("ab_idle", 32'(grant), 32'd0);
    chk("ab_no_pulse", 32'(timeout), 32'd0);
    m0_din_valid = 1'b1; m1_din_valid = 1'b1;
    tick(); #1;
    chk("ab_tie_m0", 32'(grant), 32'b01);
    bus_din_ready = 1'b1;
    tick();
    m0_din_valid = 1'b0; m1_din_valid = 1'b0; bus_din_ready = 1'b0;

    // Reset during GRANT1 (M0 finished last, so M1 is granted)
    m1_din_valid = 1'b1;
    tick(); #1;
    chk("rg_grant1", 32'(grant), 32'b10);
    rst = 1'b1; m0_din_valid = 1'b1;
    tick(); #1;
    chk("rg_grant", 32'(grant), 32'd0);
    chk("rg_bus_dev", bus_dev_id, 32'd0);
    chk("rg_bus_valid", 32'(bus_din_valid), 32'd0);
    chk("rg_bus_bits", bus_din_bits, 32'd0);
    chk("rg_bus_dout_ready", 32'(bus_dout_ready), 32'd0);
    chk("rg_m1_ready", 32'(m1_din_ready), 32'd0);
    chk("rg_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    tick(); #1;
    chk("rg_tie_m0", 32'(grant), 32'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
